// File: rtl/axis_bram_adapter_pkg.sv
// axis_bram_adapter_pkg: shared FSM state type, parameter defaults and width helper
package axis_bram_adapter_pkg;

    localparam int DEFAULT_BRAM_ADDR_LENGTH   = 9;
    localparam int DEFAULT_BRAM_WIDTH_IN_WORD = 36;
    localparam int DEFAULT_WORD_BITS          = 16;

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, STREAM, FINISH} state_t;

    // Ceiling log2, never below 1 so a counter always has at least one bit
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/bram_line_unpacker.sv
// bram_line_unpacker: shift register plus one-line holding buffer, emitting words LSB first
module bram_line_unpacker
    import axis_bram_adapter_pkg::*;
#(
    parameter int BRAM_WIDTH_IN_WORD = DEFAULT_BRAM_WIDTH_IN_WORD,
    parameter int WORD_BITS          = DEFAULT_WORD_BITS
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                load,
    input  logic                                advance,
    input  logic [BRAM_WIDTH_IN_WORD*WORD_BITS-1:0] rdata,
    output logic [WORD_BITS-1:0]                word,
    output logic                                empty,
    output logic                                last_word,
    output logic                                hold_full
);

    localparam int CW = clog2(BRAM_WIDTH_IN_WORD);

    logic [BRAM_WIDTH_IN_WORD*WORD_BITS-1:0] sr;
    logic [BRAM_WIDTH_IN_WORD*WORD_BITS-1:0] hold;
    logic [CW-1:0]                           word_cnt;
    logic                                    sr_valid;
    logic                                    refill;

    assign refill    = advance && last_word;
    assign word      = sr[WORD_BITS-1:0];
    assign empty     = !sr_valid;
    assign last_word = word_cnt == CW'(BRAM_WIDTH_IN_WORD - 1);

    // Arriving data goes straight to the shift register when it is empty or draining this cycle, else to the holding register
    always_ff @(posedge clk) begin
        if (rst) begin
            sr        <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            word_cnt  <= '0;
            sr_valid  <= 1'b0;
        end else if (refill || !sr_valid) begin
            word_cnt <= '0;
            if (hold_full) begin
                sr        <= hold;
                hold_full <= 1'b0;
                sr_valid  <= 1'b1;
            end else if (load) begin
                sr       <= rdata;
                sr_valid <= 1'b1;
            end else begin
                sr_valid <= 1'b0;
            end
        end else begin
            if (advance) begin
                sr       <= sr >> WORD_BITS;
                word_cnt <= word_cnt + 1'b1;
            end
            if (load) begin
                hold      <= rdata;
                hold_full <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/bram_axis_reader.sv
// bram_axis_reader: reads a run of BRAM lines and streams their words out over AXI-Stream
module bram_axis_reader
    import axis_bram_adapter_pkg::*;
#(
    parameter int BRAM_ADDR_LENGTH   = DEFAULT_BRAM_ADDR_LENGTH,
    parameter int BRAM_WIDTH_IN_WORD = DEFAULT_BRAM_WIDTH_IN_WORD,
    parameter int WORD_BITS          = DEFAULT_WORD_BITS
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    input  logic [BRAM_ADDR_LENGTH-1:0]             base_addr,
    input  logic [BRAM_ADDR_LENGTH-1:0]             last_offset,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    bram_en,
    output logic [BRAM_ADDR_LENGTH-1:0]             bram_addr,
    input  logic [BRAM_WIDTH_IN_WORD*WORD_BITS-1:0] bram_rdata,
    output logic [WORD_BITS-1:0]                    m_axis_tdata,
    output logic                                    m_axis_tvalid,
    input  logic                                    m_axis_tready,
    output logic                                    m_axis_tlast
);

    state_t                      state;
    logic [BRAM_ADDR_LENGTH-1:0] base_r;
    logic [BRAM_ADDR_LENGTH-1:0] last_r;
    logic [BRAM_ADDR_LENGTH:0]   issued;
    logic [BRAM_ADDR_LENGTH:0]   line_out;
    logic                        rd_pend;
    logic                        empty;
    logic                        last_word;
    logic                        hold_full;
    logic                        advance;
    logic                        prefetch;

    assign m_axis_tvalid = !empty;
    assign advance       = m_axis_tvalid && m_axis_tready;
    assign m_axis_tlast  = m_axis_tvalid && last_word && (line_out == {1'b0, last_r});
    assign prefetch      = (state == STREAM) && !bram_en && !rd_pend && !hold_full && (issued <= {1'b0, last_r});

    bram_line_unpacker #(
        .BRAM_WIDTH_IN_WORD(BRAM_WIDTH_IN_WORD),
        .WORD_BITS(WORD_BITS)
    ) u_unpacker (
        .clk(clk),
        .rst(rst),
        .load(rd_pend),
        .advance(advance),
        .rdata(bram_rdata),
        .word(m_axis_tdata),
        .empty(empty),
        .last_word(last_word),
        .hold_full(hold_full)
    );

    // Transfer control: issue line reads (first one in FETCH, the rest as prefetches) and track which line is streaming
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            bram_en   <= 1'b0;
            bram_addr <= '0;
            rd_pend   <= 1'b0;
            base_r    <= '0;
            last_r    <= '0;
            issued    <= '0;
            line_out  <= '0;
        end else begin
            rd_pend <= bram_en;
            bram_en <= 1'b0;
            done    <= 1'b0;
            if (advance && last_word) line_out <= line_out + 1'b1;
            case (state)
                IDLE: if (start) begin
                    base_r    <= base_addr;
                    last_r    <= last_offset;
                    busy      <= 1'b1;
                    issued    <= 1;
                    line_out  <= '0;
                    bram_en   <= 1'b1;
                    bram_addr <= base_addr;
                    state     <= FETCH;
                end
                FETCH:  state <= WAIT;
                WAIT:   state <= STREAM;
                STREAM: begin
                    if (prefetch) begin
                        bram_en   <= 1'b1;
                        bram_addr <= base_r + issued[BRAM_ADDR_LENGTH-1:0];
                        issued    <= issued + 1'b1;
                    end
                    if (advance && m_axis_tlast) begin
                        done  <= 1'b1;
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/bram_axis_reader.md
BRAM_AXIS_READER -- requirements
Module: bram_axis_reader

Interface
REQ-001 SHALL have parameter BRAM_ADDR_LENGTH, default 9, BRAM address width in bits.
REQ-002 SHALL have parameter BRAM_WIDTH_IN_WORD, default 36, number of stream words per BRAM line.
REQ-003 SHALL have parameter WORD_BITS, default 16, width of one stream word in bits.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, one-cycle request to begin a transfer.
REQ-007 SHALL have port base_addr, input, BRAM_ADDR_LENGTH, first BRAM line address.
REQ-008 SHALL have port last_offset, input, BRAM_ADDR_LENGTH, line count minus one.
REQ-009 SHALL have port busy, output, 1, high while a transfer is in progress.
REQ-010 SHALL have port done, output, 1, one-cycle pulse after the final word is accepted.
REQ-011 SHALL have port bram_en, output, 1, BRAM read enable.
REQ-012 SHALL have port bram_addr, output, BRAM_ADDR_LENGTH, BRAM read address.
REQ-013 SHALL have port bram_rdata, input, BRAM_WIDTH_IN_WORD*WORD_BITS, read data, valid exactly 1 cycle after bram_en.
REQ-014 SHALL have ports m_axis_tdata (output, WORD_BITS), m_axis_tvalid (output, 1), m_axis_tready (input, 1) and m_axis_tlast (output, 1), forming the AXI-Stream master.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, WAIT, STREAM and FINISH.
REQ-016 IDLE + start SHALL latch base_addr and last_offset, assert busy, and go to FETCH; start SHALL be ignored when busy=1.
REQ-017 FETCH SHALL drive bram_en=1 and bram_addr=current line for exactly one cycle, then go to WAIT.
REQ-018 WAIT SHALL capture bram_rdata into the output shift register, set word_cnt=0, and go to STREAM.
REQ-019 Word order SHALL be LSB first: word k = line bits [k*WORD_BITS +: WORD_BITS].
REQ-020 In STREAM, m_axis_tvalid SHALL be 1, and a word SHALL advance only when tvalid&&tready.
REQ-021 While tvalid=1 and tready=0, tdata and tlast SHALL be held stable.
REQ-022 Prefetch: in STREAM, if another line remains and the holding register is empty, the block SHALL issue one BRAM read of the next line and capture its data 1 cycle later into the holding register.
REQ-023 When the word at word_cnt=BRAM_WIDTH_IN_WORD-1 is accepted and the holding register is full, the holding register SHALL move into the shift register in the same cycle, giving no bubble.
REQ-024 If the holding register is not yet full at that point, tvalid SHALL drop to 0 until the data lands; this bubble SHALL never exceed 2 cycles.
REQ-025 m_axis_tlast SHALL be 1 only on word BRAM_WIDTH_IN_WORD-1 of line last_offset.
REQ-026 Acceptance of the tlast word SHALL move the FSM to FINISH; FINISH SHALL pulse done=1 for one cycle, clear busy and return to IDLE.
REQ-027 Line address SHALL be base_addr plus line index, modulo 2^BRAM_ADDR_LENGTH (wraps past all ones to zero).
REQ-028 last_offset=0 SHALL stream exactly one line; last_offset=all ones SHALL stream 2^BRAM_ADDR_LENGTH lines.
REQ-029 word_cnt width SHALL be clog2(BRAM_WIDTH_IN_WORD), and the line counter width SHALL be BRAM_ADDR_LENGTH+1 so that it does not overflow.
REQ-030 bram_en SHALL be 0 in every cycle that issues no read, and the block SHALL never write the BRAM.

Reset
REQ-031 rst=1 SHALL force state IDLE, with busy=0, done=0, bram_en=0, bram_addr=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, holding register empty, and word_cnt=0.
REQ-032 rst asserted mid-transfer SHALL abort the transfer at the next edge with no done pulse; an outstanding read's data SHALL be discarded.
REQ-033 The cycle after rst deasserts SHALL accept start.

Structure
REQ-034 The shared package axis_bram_adapter_pkg SHALL hold the FSM state enum, the default values of BRAM_ADDR_LENGTH, BRAM_WIDTH_IN_WORD and WORD_BITS, and a clog2 helper.
REQ-035 The block SHALL contain one sub-module, bram_line_unpacker: the shift register, holding register and word_cnt, with load/advance/empty/last_word flags.
REQ-036 The FSM and address generation SHALL stay in bram_axis_reader.

Verification (bench configuration: BRAM_WIDTH_IN_WORD=4, WORD_BITS=16, BRAM_ADDR_LENGTH=4; BRAM model line n = {n,3},{n,2},{n,1},{n,0} as bytes per word)
REQ-037 start with base=2, last_offset=2, tready held 1 -> 12 words 0x0200..0x0403 in order, gap-free after the first, tlast on word 12 only, and done one cycle after.
REQ-038 Same stimulus with tready toggling 1,0,0,1 repeatedly -> identical word sequence, tdata stable during every stall, and no duplicated or dropped words.
REQ-039 base=15, last_offset=1 -> reads of address 15 then 0, and words 0x0F00..0x0F03 then 0x0000..0x0003.
REQ-040 start pulsed again at word 5 of a busy transfer -> ignored, and exactly 12 words with a single done.
REQ-041 rst asserted at word 6 -> the next cycle has tvalid=0, busy=0, done=0, bram_en=0; a new start with base=0, last_offset=0 then yields exactly 4 words.
REQ-042 last_offset=0, base=7 -> exactly one BRAM read at address 7, 4 words, and tlast on 0x0703.
